obstacle_scroller: RTL and testbench
====================================

// Module: obstacle_scroller
// PURPOSE
//  Produces the obstacle positions consumed by the crash checker: two mountains plus one lava blob,
//  all scrolled right-to-left once per frame_tick. Heights come from an 8-bit LFSR; score counts mountains passed.
//  Takes the checker's game_over back and freezes the playfield.
//  Sits between the frame-rate divider and the crash checker / renderer.
// PARAMETERS
//  X_RIGHT     10'd319  respawn x coordinate (right screen edge)
//  M2_OFFSET   10'd160  initial x distance of mountain2 behind mountain1
//  STEP        10'd2    mountain pixels moved per frame_tick (>=1)
//  Y_TOP_MIN   10'd150  smallest mountain_y (tallest mountain top)
//  LAVA_Y      10'd100  fixed lava row
//  LFSR_SEED   8'hA5    LFSR reset value (non-zero)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   level; begins or restarts a game
//  frame_tick   in   1   one-cycle pulse per frame; motion only on ticks
//  game_over    in   1   from crash checker; high = crash
//  mountain1_x  out  10  mountain1 left x
//  mountain1_y  out  10  mountain1 top y
//  mountain2_x  out  10  mountain2 left x
//  mountain2_y  out  10  mountain2 top y
//  lava_x       out  10  lava x
//  lava_y       out  10  lava y (= LAVA_Y, constant)
//  score        out  8   mountains passed, saturates at 8'd255
//  running      out  1   1 in RUN state
//  frozen       out  1   1 in OVER state
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; mountain1_x=X_RIGHT; mountain2_x=X_RIGHT-M2_OFFSET;
//   mountain1_y=mountain2_y=Y_TOP_MIN+10'd63; lava_x=X_RIGHT; score=0; lfsr=LFSR_SEED; running=frozen=0.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit0. It steps only on respawn events
//   (not every clk), so sequences are deterministic per tick count.
//  FSM (all outputs registered):
//   IDLE: positions held at reset values. start=1 -> RUN next clk.
//   RUN : on frame_tick, one update (below). game_over=1 -> OVER next clk. game_over wins over
//         a coincident frame_tick: no movement, score unchanged.
//   OVER: everything frozen. start=1 && game_over=0 -> IDLE, reloading reset values except lfsr
//         (kept, so the next game differs). start while game_over=1 is ignored.
//  Update on frame_tick in RUN:
//   mountainN_x >= STEP: mountainN_x -= STEP.
//   mountainN_x <  STEP: respawn. mountainN_x=X_RIGHT; mountainN_y=Y_TOP_MIN+{4'b0,lfsr[5:0]};
//     score+=1 (saturating).
//   Both respawn on the same tick: mountain1 takes lfsr, mountain2 takes lfsr stepped once;
//     lfsr advances twice; score+=2, saturating (254 -> 255, never wraps).
//   Lava moves 2*STEP per tick. If lava_x < 2*STEP it respawns at X_RIGHT, with no score and no lfsr use.
//  All arithmetic is 10-bit unsigned; underflow is impossible by the compare-before-subtract rule.
//  lava_y is tied to LAVA_Y. It is driven here so the checker receives a real value.
//  Latency: positions change on the clk edge that samples frame_tick=1; visible one cycle later.
//  frame_tick in IDLE/OVER is ignored; frame_tick wider than one cycle moves once per high cycle.
// TESTING
//  T1 reset mid-RUN (positions mid-screen, score=7): assert reset between edges -> outputs
//     go to reset values immediately: m1_x=319, m2_x=159, m_y=213, score=0, running=0.
//  T2 start=1 then 3 frame_ticks -> m1_x=313, m2_x=153, lava_x=307, score=0, running=1.
//  T3 m1_x=1 at tick -> m1_x=319, m1_y=150+(8'hA5&6'h3F)=187, score+1, lfsr advances once.
//  T4 m1_x=1, m2_x=0 same tick -> both 319; m2_y from stepped lfsr; score+=2; from 254 -> 255.
//  T5 game_over=1 coincident with frame_tick -> no movement; frozen=1 next clk; start while
//     game_over=1 -> stays OVER; game_over=0 & start -> IDLE with reset positions, lfsr kept.
//  T6 frame_tick while IDLE or OVER -> all outputs unchanged.

Source files
------------

// File: rtl/obstacle_scroller.sv
// Obstacle generator: two mountains and one lava blob scrolling right-to-left on frame_tick.
// Mountain heights come from an 8-bit LFSR that advances only when a mountain respawns.
module obstacle_scroller #(
  parameter logic [9:0] X_RIGHT   = 10'd319,
  parameter logic [9:0] M2_OFFSET = 10'd160,
  parameter logic [9:0] STEP      = 10'd2,
  parameter logic [9:0] Y_TOP_MIN = 10'd150,
  parameter logic [9:0] LAVA_Y    = 10'd100,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       game_over,
  output logic [9:0] mountain1_x,
  output logic [9:0] mountain1_y,
  output logic [9:0] mountain2_x,
  output logic [9:0] mountain2_y,
  output logic [9:0] lava_x,
  output logic [9:0] lava_y,
  output logic [7:0] score,
  output logic       running,
  output logic       frozen
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [9:0] M_Y_RESET  = Y_TOP_MIN + 10'd63;
  localparam logic [9:0] M2_X_RESET = X_RIGHT - M2_OFFSET;
  localparam logic [9:0] LAVA_STEP  = {STEP[8:0], 1'b0};

  state_t          state_reg;
  logic [1:0][9:0] mx_reg;
  logic [1:0][9:0] my_reg;
  logic [9:0]      lava_x_reg;
  logic [7:0]      score_reg;
  logic [7:0]      lfsr_reg;
  logic            running_reg;
  logic            frozen_reg;

  logic [1:0]      respawn;
  logic [1:0][9:0] mx_next;
  logic [1:0][9:0] my_next;
  logic [2:0][7:0] lfsr_chain;
  logic [9:0]      lava_x_next;
  logic [8:0]      score_sum;
  logic [7:0]      score_next;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Mountain1 consumes the LFSR first; a coincident mountain2 respawn sees it stepped once.
  assign lfsr_chain[0] = lfsr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mountain
      assign respawn[gi]        = (mx_reg[gi] < STEP);
      assign mx_next[gi]        = respawn[gi] ? X_RIGHT : (mx_reg[gi] - STEP);
      assign my_next[gi]        = respawn[gi] ? (Y_TOP_MIN + {4'b0, lfsr_chain[gi][5:0]})
                                              : my_reg[gi];
      assign lfsr_chain[gi + 1] = respawn[gi] ? lfsr_step(lfsr_chain[gi]) : lfsr_chain[gi];
    end
  endgenerate

  assign lava_x_next = (lava_x_reg < LAVA_STEP) ? X_RIGHT : (lava_x_reg - LAVA_STEP);

  // Nine-bit sum catches the carry so the score sticks at 255 instead of wrapping.
  assign score_sum  = {1'b0, score_reg} + {8'b0, respawn[0]} + {8'b0, respawn[1]};
  assign score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      mx_reg[0]   <= X_RIGHT;
      mx_reg[1]   <= M2_X_RESET;
      my_reg[0]   <= M_Y_RESET;
      my_reg[1]   <= M_Y_RESET;
      lava_x_reg  <= X_RIGHT;
      score_reg   <= 8'd0;
      lfsr_reg    <= LFSR_SEED;
      running_reg <= 1'b0;
      frozen_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        RUN: begin
          // A crash on the same cycle as a tick freezes the field before it moves.
          if (game_over) begin
            state_reg   <= OVER;
            running_reg <= 1'b0;
            frozen_reg  <= 1'b1;
          end else if (frame_tick) begin
            mx_reg     <= mx_next;
            my_reg     <= my_next;
            lava_x_reg <= lava_x_next;
            score_reg  <= score_next;
            lfsr_reg   <= lfsr_chain[2];
          end
        end
        OVER: begin
          // lfsr_reg is deliberately not reloaded so the next game gets new heights.
          if (start && !game_over) begin
            state_reg  <= IDLE;
            frozen_reg <= 1'b0;
            mx_reg[0]  <= X_RIGHT;
            mx_reg[1]  <= M2_X_RESET;
            my_reg[0]  <= M_Y_RESET;
            my_reg[1]  <= M_Y_RESET;
            lava_x_reg <= X_RIGHT;
            score_reg  <= 8'd0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
          frozen_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign mountain1_x = mx_reg[0];
  assign mountain1_y = my_reg[0];
  assign mountain2_x = mx_reg[1];
  assign mountain2_y = my_reg[1];
  assign lava_x      = lava_x_reg;
  assign lava_y      = LAVA_Y;
  assign score       = score_reg;
  assign running     = running_reg;
  assign frozen      = frozen_reg;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench for obstacle_scroller: a default instance plus a narrow-screen instance
// that makes simultaneous respawns and score saturation reachable within a few hundred ticks.
module tb_obstacle_scroller;

  logic clk = 1'b0;
  logic reset, start, frame_tick, game_over;

  logic [9:0] a_m1x, a_m1y, a_m2x, a_m2y, a_lx, a_ly;
  logic [7:0] a_sc;
  logic       a_run, a_frz;
  logic [9:0] b_m1x, b_m1y, b_m2x, b_m2y, b_lx, b_ly;
  logic [7:0] b_sc;
  logic       b_run, b_frz;

  obstacle_scroller u_dut0 (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .game_over(game_over),
    .mountain1_x(a_m1x), .mountain1_y(a_m1y), .mountain2_x(a_m2x), .mountain2_y(a_m2y),
    .lava_x(a_lx), .lava_y(a_ly), .score(a_sc), .running(a_run), .frozen(a_frz)
  );

  obstacle_scroller #(.X_RIGHT(10'd3), .M2_OFFSET(10'd1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .game_over(game_over),
    .mountain1_x(b_m1x), .mountain1_y(b_m1y), .mountain2_x(b_m2x), .mountain2_y(b_m2y),
    .lava_x(b_lx), .lava_y(b_ly), .score(b_sc), .running(b_run), .frozen(b_frz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] m1x, m1y, m2x, m2y, lx;
    logic [7:0] sc, lfsr;
    int         st;  // 0 idle, 1 run, 2 over
  } mstate_t;

  mstate_t    md [2];
  mstate_t    sb0 [$];
  mstate_t    sb1 [$];
  logic [9:0] xr  [2] = '{10'd319, 10'd3};
  logic [9:0] off [2] = '{10'd160, 10'd1};
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  task automatic model_reset(input int k, input bit keep_lfsr);
    logic [7:0] l;
    l = keep_lfsr ? md[k].lfsr : 8'hA5;
    md[k] = '{m1x: xr[k], m1y: 10'd213, m2x: 10'(xr[k] - off[k]), m2y: 10'd213,
              lx: xr[k], sc: 8'd0, lfsr: l, st: 0};
  endtask

  task automatic model_clk(input int k);
    mstate_t s;
    int add;
    s = md[k];
    add = 0;
    case (s.st)
      0: if (start) s.st = 1;
      1: begin
        if (game_over) s.st = 2;
        else if (frame_tick) begin
          if (s.m1x < 10'd2) begin
            s.m1y = 10'(150 + int'(s.lfsr & 8'h3F));
            s.lfsr = lstep(s.lfsr);
            s.m1x = xr[k];
            add++;
          end else s.m1x = s.m1x - 10'd2;
          if (s.m2x < 10'd2) begin
            s.m2y = 10'(150 + int'(s.lfsr & 8'h3F));
            s.lfsr = lstep(s.lfsr);
            s.m2x = xr[k];
            add++;
          end else s.m2x = s.m2x - 10'd2;
          s.lx = (s.lx < 10'd4) ? xr[k] : s.lx - 10'd4;
          s.sc = (int'(s.sc) + add > 255) ? 8'd255 : 8'(int'(s.sc) + add);
        end
      end
      default: begin
        if (start && !game_over) begin
          md[k] = s;
          model_reset(k, 1'b1);
          s = md[k];
        end
      end
    endcase
    md[k] = s;
  endtask

  task automatic compare(input int k, input mstate_t e);
    string p;
    p = (k == 0) ? "u0" : "u1";
    if (k == 0) begin
      check_eq({p, " m1x"}, 32'(a_m1x), 32'(e.m1x));
      check_eq({p, " m1y"}, 32'(a_m1y), 32'(e.m1y));
      check_eq({p, " m2x"}, 32'(a_m2x), 32'(e.m2x));
      check_eq({p, " m2y"}, 32'(a_m2y), 32'(e.m2y));
      check_eq({p, " lava_x"}, 32'(a_lx), 32'(e.lx));
      check_eq({p, " lava_y"}, 32'(a_ly), 32'd100);
      check_eq({p, " score"}, 32'(a_sc), 32'(e.sc));
      check_eq({p, " running"}, 32'(a_run), 32'(e.st == 1));
      check_eq({p, " frozen"}, 32'(a_frz), 32'(e.st == 2));
    end else begin
      check_eq({p, " m1x"}, 32'(b_m1x), 32'(e.m1x));
      check_eq({p, " m1y"}, 32'(b_m1y), 32'(e.m1y));
      check_eq({p, " m2x"}, 32'(b_m2x), 32'(e.m2x));
      check_eq({p, " m2y"}, 32'(b_m2y), 32'(e.m2y));
      check_eq({p, " lava_x"}, 32'(b_lx), 32'(e.lx));
      check_eq({p, " lava_y"}, 32'(b_ly), 32'd100);
      check_eq({p, " score"}, 32'(b_sc), 32'(e.sc));
      check_eq({p, " running"}, 32'(b_run), 32'(e.st == 1));
      check_eq({p, " frozen"}, 32'(b_frz), 32'(e.st == 2));
    end
  endtask

  // Drive one cycle of inputs, queue the model's expectation, compare after the edge.
  task automatic cyc(input logic s, input logic t, input logic g);
    start = s;
    frame_tick = t;
    game_over = g;
    model_clk(0);
    model_clk(1);
    sb0.push_back(md[0]);
    sb1.push_back(md[1]);
    @(posedge clk);
    #1;
    compare(0, sb0.pop_front());
    compare(1, sb1.pop_front());
    $display("[%0t] s=%b t=%b g=%b | u0 m1=%0d m2=%0d lava=%0d sc=%0d | u1 sc=%0d",
             $time, s, t, g, a_m1x, a_m2x, a_lx, a_sc, b_sc);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    frame_tick = 1'b0;
    game_over = 1'b0;
    model_reset(0, 1'b0);
    model_reset(1, 1'b0);
    #12;
    compare(0, md[0]);
    compare(1, md[1]);
    reset = 1'b0;

    // Ticks while idle are ignored
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);

    // Three isolated ticks
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    check_eq("t2 m1x", 32'(a_m1x), 32'd313);
    check_eq("t2 m2x", 32'(a_m2x), 32'd153);
    check_eq("t2 lava_x", 32'(a_lx), 32'd307);
    check_eq("t2 running", 32'(a_run), 32'd1);

    // Held-high tick: moves every cycle; first mountain2 respawn at tick 80 uses the seed
    for (int i = 0; i < 77; i++) cyc(1'b0, 1'b1, 1'b0);
    check_eq("t3 m2x", 32'(a_m2x), 32'd319);
    check_eq("t3 m2y", 32'(a_m2y), 32'd187);
    check_eq("t3 score", 32'(a_sc), 32'd1);
    for (int i = 0; i < 523; i++) cyc(1'b0, 1'b1, 1'b0);
    check_eq("t1 pre score", 32'(a_sc), 32'd7);
    check_eq("t4 sat score", 32'(b_sc), 32'd255);

    // Asynchronous reset between edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset(0, 1'b0);
    model_reset(1, 1'b0);
    compare(0, md[0]);
    compare(1, md[1]);
    check_eq("t1 m1x", 32'(a_m1x), 32'd319);
    check_eq("t1 m2x", 32'(a_m2x), 32'd159);
    check_eq("t1 score", 32'(a_sc), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);

    // Crash coincident with a tick, then restart handling in OVER
    cyc(1'b0, 1'b1, 1'b1);
    check_eq("t5 frozen", 32'(a_frz), 32'd1);
    check_eq("t5 m1x", 32'(a_m1x), 32'd311);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("t5 idle m1x", 32'(a_m1x), 32'd319);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 90; i++) cyc(1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
